// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: shares the producer port of one fifo between N_REQ requesters.
// Round-robin arbitration with burst locking. A grant holds for at most MAX_BURST
// consecutive transfers. The data/handshake path is purely combinational.
// Optional feature macro: FIFO_ARB_STATS_EN adds per-requester saturating
// transfer counters on port xfer_cnt.
module fifo_rr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned T_SIZE    = 3,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned LOG_N     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           r2a_irdy,
    input  logic [N_REQ*T_SIZE-1:0]    r2a_data,
    output logic [N_REQ-1:0]           a2r_trdy,
    output logic                       a2f_irdy,
    output logic [T_SIZE-1:0]          a2f_data,
    input  logic                       f2a_trdy,
    output logic [LOG_N-1:0]           grant_id,
`ifdef FIFO_ARB_STATS_EN
    output logic                       busy,
    output logic [N_REQ*CNT_W-1:0]     xfer_cnt
`else
    output logic                       busy
`endif
);

    // Burst counter must be able to hold MAX_BURST itself.
    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    logic             st_q,    st_d;
    logic [LOG_N-1:0] ptr_q,   ptr_d;
    logic [LOG_N-1:0] owner_q, owner_d;
    logic [BW-1:0]    bcnt_q,  bcnt_d;

    logic [T_SIZE-1:0] req_data [N_REQ];
    logic [LOG_N-1:0]  search_idx;
    logic              search_hit;
    logic [LOG_N-1:0]  grant;
    logic              req_valid;
    logic              xfer;
    logic              owner_irdy;

    // Wrap-around successor of a requester index.
    function automatic logic [LOG_N-1:0] next_idx(input logic [LOG_N-1:0] idx);
        int unsigned n;
        n = (32'(idx) + 32'd1) % N_REQ;
        return LOG_N'(n);
    endfunction

    // Unpack the flat data bus into one word per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_data[g] = r2a_data[g*T_SIZE +: T_SIZE];
    end

    // Round-robin search starting at ptr; first requesting index wins.
    always_comb begin
        int unsigned idx;
        search_hit = 1'b0;
        search_idx = '0;
        idx        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!search_hit && r2a_irdy[LOG_N'(idx)]) begin
                search_hit = 1'b1;
                search_idx = LOG_N'(idx);
            end
        end
    end

    assign owner_irdy = r2a_irdy[owner_q];

    // Select grantee and its valid; in BURST every other requester is ignored.
    always_comb begin
        if (st_q == ST_BURST) begin
            grant     = owner_q;
            req_valid = owner_irdy;
        end else begin
            grant     = search_idx;
            req_valid = search_hit;
        end
    end

    // Fifo-facing and requester-facing outputs; all forced to zero during reset.
    always_comb begin
        a2f_irdy = 1'b0;
        a2f_data = '0;
        a2r_trdy = '0;
        grant_id = '0;
        busy     = 1'b0;
        xfer     = 1'b0;
        if (!rst) begin
            a2f_irdy = req_valid;
            busy     = (st_q == ST_BURST);
            xfer     = req_valid & f2a_trdy;
            if (req_valid) begin
                a2f_data = req_data[grant];
                grant_id = grant;
            end
            a2r_trdy[grant] = xfer;
        end
    end

    // Next-state logic for the arbitration FSM, pointer, owner and burst count.
    always_comb begin
        st_d    = st_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        bcnt_d  = bcnt_q;
        unique case (st_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        ptr_d = next_idx(grant);
                    end else begin
                        owner_d = grant;
                        bcnt_d  = BW'(1);
                        st_d    = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (!owner_irdy) begin
                    // Owner went away: release with one bubble cycle.
                    ptr_d = next_idx(owner_q);
                    st_d  = ST_IDLE;
                end else if (xfer) begin
                    bcnt_d = bcnt_q + BW'(1);
                    if (bcnt_q + BW'(1) == BW'(MAX_BURST)) begin
                        ptr_d = next_idx(owner_q);
                        st_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a partial burst is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            bcnt_q  <= '0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Per-requester accepted-transfer counters, saturating at all-ones.
    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        logic [CNT_W-1:0] cnt_q;

        // Count each accepted word until saturated.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (a2r_trdy[g] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
`endif

    // Handshake sanity: at most one acceptance per cycle, only on a real transfer.
    a_trdy_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(a2r_trdy));
    a_trdy_xfer: assert property (@(posedge clk) disable iff (rst)
        (|a2r_trdy) |-> (a2f_irdy && f2a_trdy));
    a_xfer_trdy: assert property (@(posedge clk) disable iff (rst)
        (a2f_irdy && f2a_trdy) |-> (|a2r_trdy));

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: table of per-cycle vectors for the
// burst configuration plus hand sequences for MAX_BURST=1 and the stats option.
module tb_fifo_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TS = 3;
    localparam int unsigned CW = 16;

    // req0=5, req1=6, req2=3, req3=4
    localparam logic [N*TS-1:0] D = 12'h8F5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Main DUT: MAX_BURST=4
    logic          rst;
    logic [N-1:0]  irdy;
    logic [N*TS-1:0] data;
    logic [N-1:0]  trdy;
    logic          f_irdy;
    logic [TS-1:0] f_data;
    logic          f_trdy;
    logic [1:0]    gid;
    logic          busy;

    // Second DUT: MAX_BURST=1
    logic          rst1;
    logic [N-1:0]  irdy1;
    logic [N-1:0]  trdy1;
    logic          f_irdy1;
    logic [TS-1:0] f_data1;
    logic          f_trdy1;
    logic [1:0]    gid1;
    logic          busy1;

`ifdef FIFO_ARB_STATS_EN
    logic [N*CW-1:0] cnt0;
    logic [N*CW-1:0] cnt1;
    logic          rst2;
    logic [N-1:0]  irdy2;
    logic [N-1:0]  trdy2;
    logic          f_irdy2;
    logic [TS-1:0] f_data2;
    logic [1:0]    gid2;
    logic          busy2;
    logic [N*2-1:0] cnt2;
`endif

    fifo_rr_arbiter #(.N_REQ(N), .T_SIZE(TS), .MAX_BURST(4), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .r2a_irdy (irdy),
        .r2a_data (data),
        .a2r_trdy (trdy),
        .a2f_irdy (f_irdy),
        .a2f_data (f_data),
        .f2a_trdy (f_trdy),
        .grant_id (gid),
`ifdef FIFO_ARB_STATS_EN
        .busy     (busy),
        .xfer_cnt (cnt0)
`else
        .busy     (busy)
`endif
    );

    fifo_rr_arbiter #(.N_REQ(N), .T_SIZE(TS), .MAX_BURST(1), .CNT_W(CW)) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .r2a_irdy (irdy1),
        .r2a_data (data),
        .a2r_trdy (trdy1),
        .a2f_irdy (f_irdy1),
        .a2f_data (f_data1),
        .f2a_trdy (f_trdy1),
        .grant_id (gid1),
`ifdef FIFO_ARB_STATS_EN
        .busy     (busy1),
        .xfer_cnt (cnt1)
`else
        .busy     (busy1)
`endif
    );

`ifdef FIFO_ARB_STATS_EN
    fifo_rr_arbiter #(.N_REQ(N), .T_SIZE(TS), .MAX_BURST(4), .CNT_W(2)) dut2 (
        .clk      (clk),
        .rst      (rst2),
        .r2a_irdy (irdy2),
        .r2a_data (data),
        .a2r_trdy (trdy2),
        .a2f_irdy (f_irdy2),
        .a2f_data (f_data2),
        .f2a_trdy (1'b1),
        .grant_id (gid2),
        .busy     (busy2),
        .xfer_cnt (cnt2)
    );
`endif

    typedef struct {
        logic         rst;
        logic [N-1:0] irdy;
        logic         ftrdy;
        logic [N-1:0] e_trdy;
        logic         e_irdy;
        logic [TS-1:0] e_data;
        logic [1:0]   e_gid;
        logic         e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [N-1:0] ir, input logic ft,
                       input logic [N-1:0] et, input logic ei, input logic [TS-1:0] ed,
                       input logic [1:0] eg, input logic eb);
        vec_t v;
        v.rst = r; v.irdy = ir; v.ftrdy = ft;
        v.e_trdy = et; v.e_irdy = ei; v.e_data = ed; v.e_gid = eg; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; irdy = '0; data = D; f_trdy = 1'b1;
        rst1 = 1'b1; irdy1 = '0; f_trdy1 = 1'b1;
`ifdef FIFO_ARB_STATS_EN
        rst2 = 1'b1; irdy2 = '0;
`endif

        // rst irdy ftrdy | trdy irdy data gid busy
        add(1, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);   // reset forces outputs low
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);   // idle, no request
        add(0, 4'b0101, 1, 4'b0001, 1, 5, 0, 0);   // req0 wins from ptr 0
        add(0, 4'b0101, 1, 4'b0001, 1, 5, 0, 1);
        add(0, 4'b0101, 1, 4'b0001, 1, 5, 0, 1);
        add(0, 4'b0101, 1, 4'b0001, 1, 5, 0, 1);   // 4th: burst ends, ptr=1
        add(0, 4'b0101, 1, 4'b0100, 1, 3, 2, 0);   // req2 from ptr 1
        add(0, 4'b0101, 1, 4'b0100, 1, 3, 2, 1);
        add(0, 4'b0101, 1, 4'b0100, 1, 3, 2, 1);
        add(0, 4'b0101, 1, 4'b0100, 1, 3, 2, 1);   // ptr=3
        add(0, 4'b0101, 1, 4'b0001, 1, 5, 0, 0);   // wraps back to req0
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);   // owner dropped: bubble, ptr=1
        add(0, 4'b0010, 1, 4'b0010, 1, 6, 1, 0);   // req1 burst starts
        add(0, 4'b0010, 0, 4'b0000, 1, 6, 1, 1);   // fifo full, hold
        add(0, 4'b1010, 0, 4'b0000, 1, 6, 1, 1);   // req3 ignored during burst
        add(0, 4'b1010, 0, 4'b0000, 1, 6, 1, 1);
        add(0, 4'b0010, 1, 4'b0010, 1, 6, 1, 1);
        add(0, 4'b0010, 1, 4'b0010, 1, 6, 1, 1);
        add(0, 4'b0010, 1, 4'b0010, 1, 6, 1, 1);   // 4th word, ptr=2
        add(0, 4'b1001, 1, 4'b1000, 1, 4, 3, 0);   // req3 from ptr 2
        add(0, 4'b1001, 1, 4'b1000, 1, 4, 3, 1);
        add(0, 4'b0001, 1, 4'b0000, 0, 0, 0, 1);   // req3 drops: bubble, ptr=0
        add(0, 4'b0001, 1, 4'b0001, 1, 5, 0, 0);   // pending req0 granted
        add(0, 4'b0100, 1, 4'b0000, 0, 0, 0, 1);   // req0 drops: bubble, ptr=1
        add(0, 4'b0100, 1, 4'b0100, 1, 3, 2, 0);   // req2 burst
        add(0, 4'b0100, 1, 4'b0100, 1, 3, 2, 1);   // bcnt=2
        add(1, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);   // reset mid-burst
        add(0, 4'b1001, 1, 4'b0001, 1, 5, 0, 0);   // search restarts at 0
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);   // bubble, ptr=1
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);   // idle: ptr must not move
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0101, 1, 4'b0100, 1, 3, 2, 0);   // ptr still 1 -> req2

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; irdy = vecs[i].irdy; f_trdy = vecs[i].ftrdy;
            #1;
            n_vec++;
            check("a2r_trdy", i, 32'(trdy),   32'(vecs[i].e_trdy));
            check("a2f_irdy", i, 32'(f_irdy), 32'(vecs[i].e_irdy));
            check("a2f_data", i, 32'(f_data), 32'(vecs[i].e_data));
            check("grant_id", i, 32'(gid),    32'(vecs[i].e_gid));
            check("busy",     i, 32'(busy),   32'(vecs[i].e_busy));
        end

        // MAX_BURST=1: pure round-robin, one word per grant.
        @(negedge clk);
        rst1 = 1'b1; irdy1 = 4'b1111; #1;
        n_vec++;
        check("mb1_reset_irdy", 0, 32'(f_irdy1), 32'd0);
        check("mb1_reset_trdy", 0, 32'(trdy1), 32'd0);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_d;
            @(negedge clk);
            rst1 = 1'b0; #1;
            exp_d = 4'(D >> ((k % 4) * TS)) & 4'h7;
            n_vec++;
            check("mb1_gid",  k, 32'(gid1),    32'(k % 4));
            check("mb1_trdy", k, 32'(trdy1),   32'(1 << (k % 4)));
            check("mb1_data", k, 32'(f_data1), 32'(exp_d));
            check("mb1_busy", k, 32'(busy1),   32'd0);
        end

`ifdef FIFO_ARB_STATS_EN
        // Stats with CNT_W=2: five words from req0 saturate at 3.
        @(negedge clk);
        rst2 = 1'b1; #1;
        n_vec++;
        check("stats_reset", 0, 32'(cnt2), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst2 = 1'b0; irdy2 = 4'b0001; #1;
            n_vec++;
            check("stats_xfer", k, 32'(trdy2), 32'd1);
        end
        @(negedge clk);
        irdy2 = '0; #1;
        n_vec++;
        check("stats_cnt0", 0, 32'(cnt2[1:0]), 32'd3);
        check("stats_others", 0, 32'(cnt2[7:2]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
